// File: rtl/axi_lite_core_regs_if.sv
// AXI4-Lite bus bundle for the core register bank: one write channel pair,
// one read channel pair, with master/slave views.
interface axi_lite_core_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                      awprot;
  logic                            awvalid;
  logic                            awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                      arprot;
  logic                            arvalid;
  logic                            arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_core_regs.sv
// AXI4-Lite register bank for the four-core accelerator: operands, start
// pulses, busy/done status. Define CORE_REGS_IRQ_EN for IRQ_MASK and irq.
module axi_lite_core_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] ID_VALUE           = 32'hC0DE_0004
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  axi_lite_core_regs_if.slave               s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   core_operand,
  output logic [3:0]                        core_start,
  input  logic [3:0]                        core_busy,
  input  logic [3:0]                        core_done
`ifdef CORE_REGS_IRQ_EN
  ,
  output logic                              irq
`endif
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] A_OP0    = IDX_W'(0);
  localparam logic [IDX_W-1:0] A_OP1    = IDX_W'(1);
  localparam logic [IDX_W-1:0] A_OP2    = IDX_W'(2);
  localparam logic [IDX_W-1:0] A_OP3    = IDX_W'(3);
  localparam logic [IDX_W-1:0] A_CTRL   = IDX_W'(4);
  localparam logic [IDX_W-1:0] A_STATUS = IDX_W'(5);
  localparam logic [IDX_W-1:0] A_ID     = IDX_W'(6);
  localparam logic [IDX_W-1:0] A_IRQM   = IDX_W'(7);
  localparam logic [IDX_W-1:0] A_DONE   = IDX_W'(8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic                          aw_hs;
  logic                          ar_hs;
  logic [IDX_W-1:0]              widx;
  logic [IDX_W-1:0]              ridx;
  logic [C_S_AXI_DATA_WIDTH-1:0] op_q [4];
  logic [3:0]                    done_sticky_q;
  logic [3:0]                    done_clr;
  logic [1:0]                    bresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic [1:0]                    rd_resp;
  logic                          unused_bits;

`ifdef CORE_REGS_IRQ_EN
  logic [3:0] irq_mask_q;
  logic       irq_q;
`endif

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_S_AXI_DATA_WIDTH-1:0]   old_v,
    input logic [C_S_AXI_DATA_WIDTH-1:0]   new_v,
    input logic [C_S_AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign widx = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write channel FSM: AW and W are taken only as a pair
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_hs     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          aw_hs     = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi.awready = aw_hs;
  assign s_axi.wready  = aw_hs;
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;

  // Read channel FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_hs     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          ar_hs     = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axi.arready = ar_hs;
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // Register updates land on the AW/W handshake edge
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) op_q[i] <= '0;
      bresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      if (widx == A_OP0 || widx == A_OP1 || widx == A_OP2 || widx == A_OP3) begin
        op_q[widx[1:0]] <= merge_bytes(op_q[widx[1:0]], s_axi.wdata, s_axi.wstrb);
      end
      bresp_q <= (widx > A_DONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign done_clr = (aw_hs && widx == A_DONE && s_axi.wstrb[0]) ? s_axi.wdata[3:0] : 4'b0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      core_start    <= 4'b0;
      done_sticky_q <= 4'b0;
    end else begin
      core_start    <= (aw_hs && widx == A_CTRL && s_axi.wstrb[0]) ?
                       s_axi.wdata[3:0] : 4'b0;
      // A done pulse coinciding with a clear keeps the bit set
      done_sticky_q <= (done_sticky_q & ~done_clr) | core_done;
    end
  end

  assign core_operand = {op_q[3], op_q[2], op_q[1], op_q[0]};

`ifdef CORE_REGS_IRQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_mask_q <= 4'b0;
      irq_q      <= 1'b0;
    end else begin
      if (aw_hs && widx == A_IRQM && s_axi.wstrb[0]) irq_mask_q <= s_axi.wdata[3:0];
      irq_q <= |(done_sticky_q & irq_mask_q);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (ridx)
      A_OP0, A_OP1, A_OP2, A_OP3: rd_word = op_q[ridx[1:0]];
      A_CTRL:   rd_word = '0;
      A_STATUS: rd_word = {24'b0, core_busy, done_sticky_q};
      A_ID:     rd_word = ID_VALUE;
`ifdef CORE_REGS_IRQ_EN
      A_IRQM:   rd_word = {28'b0, irq_mask_q};
`else
      A_IRQM:   rd_word = '0;
`endif
      A_DONE:   rd_word = '0;
      default:  rd_resp = RESP_SLVERR;
    endcase
  end

  // Read data captured at the AR handshake, so a same-cycle write is not seen
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_word;
      rresp_q <= rd_resp;
    end
  end

endmodule

// File: tb/tb_axi_lite_core_regs.sv
// Directed self-checking bench for axi_lite_core_regs (default build; the
// irq steps run when CORE_REGS_IRQ_EN is defined).
module tb_axi_lite_core_regs;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [127:0] core_operand;
  logic [3:0]   core_start;
  logic [3:0]   core_busy = 4'b0;
  logic [3:0]   core_done = 4'b0;
`ifdef CORE_REGS_IRQ_EN
  logic         irq;
`endif

  int compared   = 0;
  int mismatched = 0;

  axi_lite_core_regs_if bus ();

  axi_lite_core_regs dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .s_axi        (bus),
    .core_operand (core_operand),
    .core_start   (core_start),
    .core_busy    (core_busy),
    .core_done    (core_done)
`ifdef CORE_REGS_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] done_p, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    core_done = done_p;
    #1;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge ACLK); #1; n++; end
    check("aw_accept", bus.awready, 1'b1);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; core_done = 4'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(posedge ACLK); #1; n++; end
    check("b_valid", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge ACLK); #1; n++; end
    check("ar_accept", bus.arready, 1'b1);
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(posedge ACLK); #1; n++; end
    check("r_valid", bus.rvalid, 1'b1);
    d = bus.rdata; resp = bus.rresp;
    @(posedge ACLK); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  bs;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_bresp", bus.bresp, 2'b00);
    check("rst_operand", core_operand, 128'h0);
    check("rst_start", core_start, 4'b0);
    ARESETN = 1'b1;

    // Operand writes and readback
    axi_write(6'h00, 32'h1, 4'hF, 4'b0, bs); check("op0_bresp", bs, 2'b00);
    axi_write(6'h04, 32'h2, 4'hF, 4'b0, bs); check("op1_bresp", bs, 2'b00);
    axi_write(6'h08, 32'h3, 4'hF, 4'b0, bs); check("op2_bresp", bs, 2'b00);
    axi_write(6'h0C, 32'h4, 4'hF, 4'b0, bs); check("op3_bresp", bs, 2'b00);
    axi_read(6'h00, rd, rs); check("op0_rd", rd, 32'h1); check("op0_rresp", rs, 2'b00);
    axi_read(6'h04, rd, rs); check("op1_rd", rd, 32'h2); check("op1_rresp", rs, 2'b00);
    axi_read(6'h08, rd, rs); check("op2_rd", rd, 32'h3); check("op2_rresp", rs, 2'b00);
    axi_read(6'h0C, rd, rs); check("op3_rd", rd, 32'h4); check("op3_rresp", rs, 2'b00);
    check("operand_bus", core_operand,
          128'h00000004_00000003_00000002_00000001);

    // Same-cycle read and write of OP0: the read sees the old value
    @(negedge ACLK);
    bus.awaddr = 6'h00; bus.wdata = 32'h99; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    bus.araddr = 6'h00; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("rw_same_rvalid", bus.rvalid, 1'b1);
    check("rw_same_rdata", bus.rdata, 32'h1);
    @(posedge ACLK); #1;
    axi_read(6'h00, rd, rs); check("rw_after_rdata", rd, 32'h99);

    // Byte strobes
    axi_write(6'h04, 32'h0, 4'hF, 4'b0, bs);
    axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 4'b0, bs);
    axi_read(6'h04, rd, rs); check("strb_rd", rd, 32'h00BB00DD);

    // CTRL start pulse, issued while core 0 is busy
    core_busy = 4'b0001;
    @(negedge ACLK);
    bus.awaddr = 6'h10; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    #1;
    check("start_pre", core_start, 4'b0000);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("start_pulse", core_start, 4'b0101);
    @(posedge ACLK); #1;
    check("start_drop", core_start, 4'b0000);
    axi_read(6'h10, rd, rs); check("ctrl_rd", rd, 32'h0);

    // done_sticky set, set-vs-clear priority, clear
    @(negedge ACLK); core_done = 4'b0100;
    @(negedge ACLK); core_done = 4'b0000;
    axi_read(6'h14, rd, rs); check("status_done", rd, 32'h14);
    axi_write(6'h20, 32'h4, 4'hF, 4'b0100, bs);
    axi_read(6'h14, rd, rs); check("status_setwins", rd, 32'h14);
    axi_write(6'h20, 32'h4, 4'hF, 4'b0, bs);
    axi_read(6'h14, rd, rs); check("status_clr", rd, 32'h10);
    core_busy = 4'b0;

    // Back-pressure on B: second write must wait
    @(negedge ACLK);
    bus.awaddr = 6'h0C; bus.wdata = 32'h11; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    #1;
    check("bp_first_acc", bus.awready, 1'b1);
    @(posedge ACLK); #1;
    bus.awaddr = 6'h08; bus.wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_bvalid_hold", bus.bvalid, 1'b1);
      check("bp_awready_low", bus.awready, 1'b0);
      check("bp_bresp", bus.bresp, 2'b00);
    end
    bus.bready = 1'b1;
    @(posedge ACLK); #1;
    check("bp_second_acc", bus.awready, 1'b1);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bp_second_b", bus.bvalid, 1'b1);
    @(posedge ACLK); #1;
    axi_read(6'h0C, rd, rs); check("bp_op3", rd, 32'h11);
    axi_read(6'h08, rd, rs); check("bp_op2", rd, 32'h22);

    // Unmapped and read-only addresses
    axi_read(6'h30, rd, rs); check("unmap_rdata", rd, 32'h0); check("unmap_rresp", rs, 2'b10);
    axi_write(6'h30, 32'hFFFF, 4'hF, 4'b0, bs); check("unmap_bresp", bs, 2'b10);
    axi_read(6'h18, rd, rs); check("id_rd", rd, 32'hC0DE0004); check("id_rresp", rs, 2'b00);
    axi_write(6'h18, 32'h0, 4'hF, 4'b0, bs); check("id_wr_bresp", bs, 2'b00);
    axi_read(6'h18, rd, rs); check("id_ro", rd, 32'hC0DE0004);

`ifdef CORE_REGS_IRQ_EN
    axi_write(6'h1C, 32'h1, 4'hF, 4'b0, bs);
    axi_read(6'h1C, rd, rs); check("irqm_rd", rd, 32'h1);
    @(negedge ACLK); core_done = 4'b0001;
    @(negedge ACLK); core_done = 4'b0000;
    check("irq_lat", irq, 1'b0);
    @(negedge ACLK);
    check("irq_set", irq, 1'b1);
    axi_write(6'h20, 32'h1, 4'hF, 4'b0, bs);
    check("irq_clr", irq, 1'b0);
`else
    axi_write(6'h1C, 32'hF, 4'hF, 4'b0, bs); check("irqm_wr_bresp", bs, 2'b00);
    axi_read(6'h1C, rd, rs); check("irqm_rd", rd, 32'h0); check("irqm_rresp", rs, 2'b00);
`endif

    // Asynchronous reset aborts a pending write response
    @(negedge ACLK);
    bus.awaddr = 6'h00; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("arst_pending", bus.bvalid, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_bvalid", bus.bvalid, 1'b0);
    check("arst_operand", core_operand, 128'h0);
    @(negedge ACLK);
    ARESETN = 1'b1; bus.bready = 1'b1;
    axi_read(6'h00, rd, rs); check("arst_op0", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
